// File: rtl/vend_ctrl_multi_pkg.sv
// Shared types and helpers for the multi-item vending controller: FSM state
// encoding plus one-hot utilities used for item and coin selection.
package vend_ctrl_multi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_CHANGE,
    ST_REFUND
  } vend_state_e;

  localparam int SEL_MAX = 32;
  localparam logic [SEL_MAX-1:0] SEL_ONE = SEL_MAX'(1);

  function automatic logic is_onehot(input logic [SEL_MAX-1:0] v);
    return (v != '0) && ((v & (v - SEL_ONE)) == '0);
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] onehot_to_idx(input logic [SEL_MAX-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = SEL_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [SEL_MAX-1:0] lowest_bit(input logic [SEL_MAX-1:0] v);
    return v & (~v + SEL_ONE);
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Board-side signal bundle of the vending controller. Inputs are raw levels
// (no valid/ready): buttons are asynchronous presses, switches are static levels;
// coin_rej is a one-cycle pulse, all other outputs are levels decoded from state.
interface vend_ctrl_multi_if #(
  parameter int N_ITEMS  = 4,
  parameter int N_COINS  = 3,
  parameter int CREDIT_W = 8
);
  logic [N_COINS-1:0]  coin_btn;
  logic                cancel_btn;
  logic [N_ITEMS-1:0]  sel_sw;
  logic [N_ITEMS-1:0]  vend;
  logic                coin_rej;
  logic [CREDIT_W-1:0] change_val;
  logic [CREDIT_W-1:0] disp_val;
  logic [2:0]          state_led;
  vend_ctrl_multi_pkg::vend_state_e dbg_state;

  modport master (
    output coin_btn, cancel_btn, sel_sw,
    input  vend, coin_rej, change_val, disp_val, state_led, dbg_state
  );

  modport slave (
    input  coin_btn, cancel_btn, sel_sw,
    output vend, coin_rej, change_val, disp_val, state_led, dbg_state
  );
endinterface

// File: rtl/vend_ctrl_multi_btn_pulse.sv
// Two-flop synchroniser plus rising-edge detect for one raw button; emits a
// registered one-cycle pulse three clocks after the pin rises.
module vend_ctrl_multi_btn_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  logic s1_q, s2_q, s3_q, pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= s2_q & ~s3_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/vend_ctrl_multi.sv
// Parametrised vending controller: collects coins into credit, vends the
// selected item once credit covers its price, returns change or refunds.
module vend_ctrl_multi
  import vend_ctrl_multi_pkg::*;
#(
  parameter int N_ITEMS     = 4,
  parameter int CREDIT_W    = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd15, 8'd12, 8'd10, 8'd8},
  parameter int N_COINS     = 3,
  parameter logic [N_COINS*CREDIT_W-1:0] COIN_VALS = {8'd10, 8'd5, 8'd2},
  parameter int MAX_CREDIT  = 50,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int HOLD_CYC    = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  vend_ctrl_multi_if.slave io
);
  localparam int IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int CIDX_W  = (N_COINS > 1) ? $clog2(N_COINS) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]    HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE      = CNT_W'(1);
  localparam logic [CREDIT_W:0]   MAX_SUM      = (CREDIT_W + 1)'(MAX_CREDIT);

  vend_state_e          state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [CREDIT_W-1:0]  change_q, change_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_ITEMS-1:0]   sel_s1_q, sel_q;

  logic [CREDIT_W-1:0]  price_tbl [N_ITEMS];
  logic [CREDIT_W-1:0]  coin_tbl  [N_COINS];
  logic [N_COINS-1:0]   coin_p, coin_first;
  logic                 cancel_p, coin_any, coin_extra, coin_rej_c;
  logic [CIDX_W-1:0]    coin_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;
  logic [CREDIT_W-1:0]  price, coin_val;
  logic [CREDIT_W:0]    sum;

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_price
    assign price_tbl[i] = PRICES[i*CREDIT_W +: CREDIT_W];
  end

  for (genvar j = 0; j < N_COINS; j++) begin : g_coin
    assign coin_tbl[j] = COIN_VALS[j*CREDIT_W +: CREDIT_W];
    vend_ctrl_multi_btn_pulse u_coin (
      .clk(clk), .rst_n(rst_n), .btn_i(io.coin_btn[j]), .pulse_o(coin_p[j])
    );
  end

  vend_ctrl_multi_btn_pulse u_cancel (
    .clk(clk), .rst_n(rst_n), .btn_i(io.cancel_btn), .pulse_o(cancel_p)
  );

  // Only the lowest-index coin of a simultaneous group is considered.
  assign coin_any   = |coin_p;
  assign coin_first = N_COINS'(lowest_bit(SEL_MAX'(coin_p)));
  assign coin_extra = |(coin_p & ~coin_first);
  assign coin_idx   = CIDX_W'(onehot_to_idx(SEL_MAX'(coin_p)));
  assign coin_val   = coin_tbl[coin_idx];
  assign sum        = {1'b0, credit_q} + {1'b0, coin_val};

  assign sel_valid  = is_onehot(SEL_MAX'(sel_q));
  assign sel_idx    = IDX_W'(onehot_to_idx(SEL_MAX'(sel_q)));
  assign price      = sel_valid ? price_tbl[sel_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      change_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      sel_s1_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_s1_q <= io.sel_sw;
      sel_q    <= sel_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    change_d   = change_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    coin_rej_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        credit_d = '0;
        change_d = '0;
        cnt_d    = '0;
        if (cancel_p) begin
          coin_rej_c = coin_any;
        end else if (coin_any) begin
          if (sel_valid && sum <= MAX_SUM) begin
            credit_d   = sum[CREDIT_W-1:0];
            state_d    = ST_COLLECT;
            coin_rej_c = coin_extra;
          end else begin
            coin_rej_c = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cancel_p || cnt_q >= TIMEOUT_LAST) begin
          state_d    = ST_REFUND;
          change_d   = credit_q;
          cnt_d      = '0;
          coin_rej_c = coin_any;
        end else if (sel_valid && credit_q >= price) begin
          // Credit compared here is last cycle's update, so a cheaper reselection also vends.
          state_d    = ST_VEND;
          change_d   = credit_q - price;
          idx_d      = sel_idx;
          cnt_d      = '0;
          coin_rej_c = coin_any;
        end else if (coin_any) begin
          cnt_d      = '0;
          coin_rej_c = coin_extra;
          if (sum <= MAX_SUM) credit_d = sum[CREDIT_W-1:0];
          else                coin_rej_c = 1'b1;
        end
      end
      ST_VEND: begin
        cnt_d      = cnt_q + CNT_ONE;
        coin_rej_c = coin_any;
        if (cnt_q >= HOLD_LAST) begin
          cnt_d = '0;
          if (change_q != '0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d  = ST_IDLE;
            credit_d = '0;
          end
        end
      end
      ST_CHANGE, ST_REFUND: begin
        cnt_d      = cnt_q + CNT_ONE;
        coin_rej_c = coin_any;
        if (cnt_q >= HOLD_LAST) begin
          cnt_d    = '0;
          state_d  = ST_IDLE;
          credit_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    io.vend       = '0;
    io.change_val = '0;
    io.disp_val   = '0;
    io.state_led  = 3'b000;
    case (state_q)
      ST_IDLE:    io.disp_val = price;
      ST_COLLECT: begin
        io.disp_val  = credit_q;
        io.state_led = 3'b001;
      end
      ST_VEND: begin
        io.vend       = N_ITEMS'(1) << idx_q;
        io.change_val = change_q;
        io.disp_val   = price_tbl[idx_q];
        io.state_led  = 3'b010;
      end
      ST_CHANGE, ST_REFUND: begin
        io.change_val = change_q;
        io.disp_val   = change_q;
        io.state_led  = 3'b100;
      end
      default: ;
    endcase
  end

  assign io.coin_rej  = coin_rej_c;
  assign io.dbg_state = state_q;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: idle display table, hand-written
// corner sequences, and randomised sessions against a transaction-level model.
module tb_vend_ctrl_multi;
  import vend_ctrl_multi_pkg::*;

  localparam int MAX_CR = 50;
  localparam int HOLD   = 20;
  localparam int TMO    = 200;

  logic clk;
  logic rst_n;

  vend_ctrl_multi_if #(.N_ITEMS(4), .N_COINS(3), .CREDIT_W(8)) io ();

  vend_ctrl_multi #(.TIMEOUT_CYC(TMO), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .io(io)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int price_ref [4] = '{8, 10, 12, 15};
  int coin_ref  [3] = '{2, 5, 10};
  logic [7:0] exp_q [$];

  // monitor, sampled on the falling edge
  int unsigned cyc = 0, vend_cyc = 0, rej_cnt = 0, chg_cyc = 0;
  logic [3:0]  last_vend = '0;
  logic [7:0]  chg_disp = '0;
  always @(negedge clk) begin
    cyc++;
    if (io.vend != 4'b0000) begin
      vend_cyc++;
      last_vend = io.vend;
    end
    if (io.coin_rej) rej_cnt++;
    if (io.dbg_state == ST_CHANGE) begin
      chg_cyc++;
      chg_disp = io.disp_val;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    io.coin_btn = '0;
    io.cancel_btn = 1'b0;
    io.sel_sw = '0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic press_coin(input int j);
    io.coin_btn[j] = 1'b1;
    tick(4);
    io.coin_btn[j] = 1'b0;
    tick(4);
  endtask

  task automatic press_cancel();
    io.cancel_btn = 1'b1;
    tick(4);
    io.cancel_btn = 1'b0;
    tick(4);
  endtask

  task automatic wait_state(input vend_state_e s, input int budget, input string name);
    int n;
    n = 0;
    while (io.dbg_state != s && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 32'(io.dbg_state), 32'(s));
  endtask

  function automatic bit ref_valid(input logic [3:0] sel);
    return $countones(sel) == 1;
  endfunction

  function automatic int ref_price(input logic [3:0] sel);
    if (!ref_valid(sel)) return 0;
    for (int i = 0; i < 4; i++) if (sel[i]) return price_ref[i];
    return 0;
  endfunction

  function automatic logic [3:0] rand_sel();
    int r;
    logic [3:0] bad [3];
    bad = '{4'b0101, 4'b1100, 4'b1111};
    r = $urandom_range(0, 5);
    if (r < 4) return 4'(1 << r);
    if (r == 4) return 4'b0000;
    return bad[$urandom_range(0, 2)];
  endfunction

  task automatic run_session();
    logic [3:0] cur_sel;
    int credit, exp_rej, j, v;
    int unsigned r0;
    bit collecting, vended;
    cur_sel = rand_sel();
    io.sel_sw = cur_sel;
    tick(4);
    r0 = rej_cnt;
    credit = 0; exp_rej = 0; collecting = 0; vended = 0;
    for (int k = 0; k < int'($urandom_range(1, 8)) && !vended; k++) begin
      j = $urandom_range(0, 2);
      v = coin_ref[j];
      press_coin(j);
      if (!collecting) begin
        if (ref_valid(cur_sel)) begin
          credit = v;
          collecting = 1;
        end else exp_rej++;
      end else if (credit + v > MAX_CR) exp_rej++;
      else credit += v;
      if (collecting && ref_valid(cur_sel) && credit >= ref_price(cur_sel)) vended = 1;
      else begin
        exp_q.push_back(8'(collecting ? credit : ref_price(cur_sel)));
        chk("rnd_disp", io.disp_val, exp_q.pop_front());
      end
      if (k == 0 && collecting && !vended && $urandom_range(0, 1) == 1) begin
        cur_sel = rand_sel();
        io.sel_sw = cur_sel;
        tick(6);
        if (ref_valid(cur_sel) && credit >= ref_price(cur_sel)) vended = 1;
      end
    end
    if (vended) begin
      chk("rnd_vend", io.vend, cur_sel);
      chk("rnd_change", io.change_val, credit - ref_price(cur_sel));
      wait_state(ST_IDLE, 100, "rnd_vend_idle");
    end else if (collecting) begin
      press_cancel();
      chk("rnd_refund_state", 32'(io.dbg_state), 32'(ST_REFUND));
      chk("rnd_refund_val", io.change_val, credit);
      wait_state(ST_IDLE, 100, "rnd_refund_idle");
    end else begin
      chk("rnd_idle_state", 32'(io.dbg_state), 32'(ST_IDLE));
    end
    chk("rnd_rej", rej_cnt - r0, exp_rej);
  endtask

  typedef struct {
    logic [3:0] sel;
    logic [7:0] disp;
  } idle_vec_t;

  initial begin : watchdog
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    idle_vec_t tbl [8];
    int unsigned v0, r0, c0, t0, t1;
    int n;
    tbl = '{'{4'b0000, 8'd0},  '{4'b0001, 8'd8},  '{4'b0010, 8'd10}, '{4'b0100, 8'd12},
            '{4'b1000, 8'd15}, '{4'b0110, 8'd0},  '{4'b1111, 8'd0},  '{4'b0011, 8'd0}};

    // reset state, with inputs active while held in reset
    rst_n = 1'b0;
    io.coin_btn = 3'b111;
    io.cancel_btn = 1'b1;
    io.sel_sw = 4'b1000;
    tick(4);
    chk("rst_vend", io.vend, 0);
    chk("rst_rej", io.coin_rej, 0);
    chk("rst_change", io.change_val, 0);
    chk("rst_disp", io.disp_val, 0);
    chk("rst_led", io.state_led, 0);
    chk("rst_state", 32'(io.dbg_state), 32'(ST_IDLE));
    do_reset();

    // idle price display table
    for (int i = 0; i < 8; i++) begin
      io.sel_sw = tbl[i].sel;
      tick(4);
      chk("idle_disp", io.disp_val, tbl[i].disp);
      chk("idle_led", io.state_led, 3'b000);
    end

    // 1: price 12, coins 2,5,10 -> vend with change 5
    io.sel_sw = 4'b0100; tick(4);
    v0 = vend_cyc; c0 = chg_cyc;
    press_coin(0); chk("t1_credit2", io.disp_val, 2); chk("t1_led", io.state_led, 3'b001);
    press_coin(1); chk("t1_credit7", io.disp_val, 7);
    press_coin(2);
    chk("t1_state_vend", 32'(io.dbg_state), 32'(ST_VEND));
    chk("t1_vend", io.vend, 4'b0100);
    chk("t1_change", io.change_val, 5);
    wait_state(ST_IDLE, 100, "t1_idle");
    chk("t1_vend_cycles", vend_cyc - v0, HOLD);
    chk("t1_change_cycles", chg_cyc - c0, HOLD);
    chk("t1_change_disp", chg_disp, 5);
    chk("t1_idle_change", io.change_val, 0);
    press_coin(0); chk("t1_credit_cleared", io.disp_val, 2);
    press_cancel(); wait_state(ST_IDLE, 100, "t1_idle2");

    // 2: price 8, coins 5,2, cancel -> refund 7
    io.sel_sw = 4'b0001; tick(4);
    v0 = vend_cyc;
    press_coin(1); chk("t2_credit5", io.disp_val, 5);
    press_coin(0); chk("t2_credit7", io.disp_val, 7);
    press_cancel();
    chk("t2_state", 32'(io.dbg_state), 32'(ST_REFUND));
    chk("t2_change", io.change_val, 7);
    chk("t2_disp", io.disp_val, 7);
    chk("t2_led", io.state_led, 3'b100);
    wait_state(ST_IDLE, 100, "t2_idle");
    chk("t2_no_vend", vend_cyc - v0, 0);

    // 3: price 10, coin 5, inactivity -> refund 200 cycles after the credit update
    io.sel_sw = 4'b0010; tick(4);
    io.coin_btn[1] = 1'b1;
    n = 0;
    while (io.disp_val != 8'd5 && n < 20) begin tick(1); n++; end
    chk("t3_credit", io.disp_val, 5);
    t0 = cyc;
    io.coin_btn[1] = 1'b0;
    n = 0;
    while (io.dbg_state != ST_REFUND && n < 300) begin tick(1); n++; end
    t1 = cyc;
    chk("t3_timeout_cycles", t1 - t0, TMO);
    chk("t3_change", io.change_val, 5);
    wait_state(ST_IDLE, 100, "t3_idle");

    // 4: price 15, five coins of 10 -> vend at 20, later coins rejected
    io.sel_sw = 4'b1000; tick(4);
    r0 = rej_cnt; v0 = vend_cyc;
    for (int k = 0; k < 5; k++) press_coin(2);
    wait_state(ST_IDLE, 100, "t4_idle");
    chk("t4_vend", last_vend, 4'b1000);
    chk("t4_vend_cycles", vend_cyc - v0, HOLD);
    chk("t4_change_disp", chg_disp, 5);
    chk("t4_rej", rej_cnt - r0, 3);

    // ceiling: reach 48 with no valid selection, 5 rejected, 2 lands exactly on 50
    press_coin(2); chk("ceil_first", io.disp_val, 10);
    io.sel_sw = 4'b0000; tick(4);
    for (int k = 0; k < 3; k++) press_coin(2);
    for (int k = 0; k < 4; k++) press_coin(0);
    chk("ceil_48", io.disp_val, 48);
    r0 = rej_cnt;
    press_coin(1);
    chk("ceil_rej", rej_cnt - r0, 1);
    chk("ceil_hold48", io.disp_val, 48);
    press_coin(0);
    chk("ceil_50", io.disp_val, 50);
    press_cancel();
    chk("ceil_refund", io.change_val, 50);
    wait_state(ST_IDLE, 100, "ceil_idle");

    // cancel and coin together: cancel wins
    io.sel_sw = 4'b1000; tick(4);
    press_coin(1);
    r0 = rej_cnt;
    io.coin_btn[2] = 1'b1; io.cancel_btn = 1'b1; tick(4);
    io.coin_btn[2] = 1'b0; io.cancel_btn = 1'b0; tick(4);
    chk("cc_state", 32'(io.dbg_state), 32'(ST_REFUND));
    chk("cc_refund", io.change_val, 5);
    chk("cc_rej", rej_cnt - r0, 1);
    wait_state(ST_IDLE, 100, "cc_idle");

    // two coins together: lowest index taken
    press_coin(0);
    r0 = rej_cnt;
    io.coin_btn = 3'b101; tick(4);
    io.coin_btn = 3'b000; tick(4);
    chk("multi_credit", io.disp_val, 4);
    chk("multi_rej", rej_cnt - r0, 1);
    press_cancel(); wait_state(ST_IDLE, 100, "multi_idle");

    // 5: invalid select rejects; a held button pulses once
    io.sel_sw = 4'b0110; tick(4);
    r0 = rej_cnt;
    press_coin(2);
    chk("t5_rej", rej_cnt - r0, 1);
    chk("t5_state", 32'(io.dbg_state), 32'(ST_IDLE));
    chk("t5_disp", io.disp_val, 0);
    io.sel_sw = 4'b0001; tick(4);
    io.coin_btn[0] = 1'b1; tick(50);
    chk("t5_held_credit", io.disp_val, 2);
    chk("t5_held_state", 32'(io.dbg_state), 32'(ST_COLLECT));
    io.coin_btn[0] = 1'b0; tick(4);
    press_cancel(); wait_state(ST_IDLE, 100, "t5_idle");

    // 6: exact price skips CHANGE; reset during VEND drops vend at once
    io.sel_sw = 4'b0010; tick(4);
    c0 = chg_cyc; v0 = vend_cyc;
    press_coin(2);
    chk("t6_state", 32'(io.dbg_state), 32'(ST_VEND));
    chk("t6_change", io.change_val, 0);
    wait_state(ST_IDLE, 100, "t6_idle");
    chk("t6_no_change", chg_cyc - c0, 0);
    chk("t6_vend_cycles", vend_cyc - v0, HOLD);
    press_coin(2);
    chk("t6_vend_again", io.vend, 4'b0010);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vend", io.vend, 0);
    chk("t6_rst_state", 32'(io.dbg_state), 32'(ST_IDLE));
    chk("t6_rst_led", io.state_led, 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t6_after_disp", io.disp_val, 10);
    press_coin(1);
    chk("t6_credit_lost", io.disp_val, 5);
    press_cancel(); wait_state(ST_IDLE, 100, "t6_idle2");

    // randomised sessions
    for (int s = 0; s < 25; s++) run_session();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
